ks_data_path_gen: RTL and testbench

Parametrised K&S data path: instruction register, program counter, general-purpose register bank, ALU and flag register. Width, register count and memory address width are configurable. The ALU gains single-cycle shifts and an iterative multiply with a busy/done handshake. Sits between the K&S control unit (which drives every enable/select) and the unified program/data RAM.

---
 rtl/k_and_s_pkg.sv | 61 ++++++
 rtl/ks_mul_iter.sv | 75 +++++++
 rtl/ks_data_path_gen.sv | 207 ++++++++++++++++++++
 tb/tb_ks_data_path_gen.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S data path: decoded instruction enum, ALU operation codes,
// multiplier FSM states and the 8-bit opcode encodings.
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNOV,
    I_BNNEG,
    I_HALT,
    I_MUL,
    I_SHL,
    I_SHR
  } decoded_instruction_type;

  typedef enum logic [2:0] {
    OP_OR     = 3'b000,
    OP_ADD    = 3'b001,
    OP_SUB    = 3'b010,
    OP_AND    = 3'b011,
    OP_SHL    = 3'b100,
    OP_SHR    = 3'b101,
    OP_MUL    = 3'b110,
    OP_PASS_A = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_MUL    = 8'hA5;
  localparam logic [7:0] OPC_SHL    = 8'hA6;
  localparam logic [7:0] OPC_SHR    = 8'hA7;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BZERO  = 8'h02;
  localparam logic [7:0] OPC_BNEG   = 8'h03;
  localparam logic [7:0] OPC_BOV    = 8'h05;
  localparam logic [7:0] OPC_BNOV   = 8'h06;
  localparam logic [7:0] OPC_BNNEG  = 8'h0A;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

endpackage

// File: rtl/ks_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for DATA_W cycles.
// Handshake: start is accepted only in IDLE; busy spans the DATA_W shift-add cycles, done pulses once with product valid.
module ks_mul_iter
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);

  mul_state_t            state;
  mul_state_t            next_state;
  logic [2*DATA_W-1:0]   acc;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [CNT_W-1:0]      cnt;
  logic                  last_step;

  assign last_step = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MUL_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      MUL_IDLE: if (start) next_state = MUL_RUN;
      MUL_RUN:  if (last_step) next_state = MUL_DONE;
      MUL_DONE: next_state = MUL_IDLE;
      default:  next_state = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL_RUN);
    done = (state == MUL_DONE);
  end

  // The accumulator doubles as the result register, so it holds until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == MUL_IDLE && start) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (state == MUL_RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  assign product = acc;

endmodule

// File: rtl/ks_data_path_gen.sv
// K&S data path: IR, PC, register bank, ALU (with shifts) and flag register.
// Macro KS_DP_MUL_EN adds the MUL opcode and the iterative multiplier.
module ks_data_path_gen
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic [2:0]              operation,
  input  logic                    alu_start,
  output logic                    alu_busy,
  output logic                    alu_done,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  localparam int RS = $clog2(NUM_REGS);

  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [7:0]        opcode;
  logic [RS-1:0]     a_addr;
  logic [RS-1:0]     b_addr;
  logic [RS-1:0]     c_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              rrr_fmt;
  logic [DATA_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_b;
  logic [DATA_W-1:0] bus_c;
  logic [DATA_W-1:0] alu_out;
  logic              alu_uov;
  logic              alu_sov;
  logic [DATA_W-1:0] b_op;
  logic              cin;
  logic [DATA_W:0]   sum_ext;
  logic              carry_into_msb;
  alu_op_t           op;
  logic              unused_ir_bits;

  assign opcode         = ir[DATA_W-1 -: 8];
  assign op             = alu_op_t'(operation);
  assign unused_ir_bits = ^ir;

  always_comb begin
    decoded_instruction = I_NOP;
    a_addr   = '0;
    b_addr   = '0;
    c_addr   = '0;
    mem_addr = '0;
    rrr_fmt  = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        decoded_instruction = I_LOAD;
        mem_addr = ir[ADDR_W-1:0];
        c_addr   = ir[ADDR_W+RS-1:ADDR_W];
      end
      OPC_STORE: begin
        decoded_instruction = I_STORE;
        mem_addr = ir[ADDR_W-1:0];
        c_addr   = ir[ADDR_W+RS-1:ADDR_W];
        a_addr   = ir[ADDR_W+RS-1:ADDR_W];
      end
      OPC_MOVE: begin
        decoded_instruction = I_MOVE;
        c_addr = ir[2*RS-1:RS];
        a_addr = ir[RS-1:0];
        b_addr = ir[RS-1:0];
      end
      OPC_ADD: begin decoded_instruction = I_ADD; rrr_fmt = 1'b1; end
      OPC_SUB: begin decoded_instruction = I_SUB; rrr_fmt = 1'b1; end
      OPC_AND: begin decoded_instruction = I_AND; rrr_fmt = 1'b1; end
      OPC_OR:  begin decoded_instruction = I_OR;  rrr_fmt = 1'b1; end
      OPC_SHL: begin decoded_instruction = I_SHL; rrr_fmt = 1'b1; end
      OPC_SHR: begin decoded_instruction = I_SHR; rrr_fmt = 1'b1; end
`ifdef KS_DP_MUL_EN
      OPC_MUL: begin decoded_instruction = I_MUL; rrr_fmt = 1'b1; end
`endif
      OPC_BRANCH: begin decoded_instruction = I_BRANCH; mem_addr = ir[ADDR_W-1:0]; end
      OPC_BZERO:  begin decoded_instruction = I_BZERO;  mem_addr = ir[ADDR_W-1:0]; end
      OPC_BNEG:   begin decoded_instruction = I_BNEG;   mem_addr = ir[ADDR_W-1:0]; end
      OPC_BOV:    begin decoded_instruction = I_BOV;    mem_addr = ir[ADDR_W-1:0]; end
      OPC_BNOV:   begin decoded_instruction = I_BNOV;   mem_addr = ir[ADDR_W-1:0]; end
      OPC_BNNEG:  begin decoded_instruction = I_BNNEG;  mem_addr = ir[ADDR_W-1:0]; end
      OPC_HALT:   decoded_instruction = I_HALT;
      default:    decoded_instruction = I_NOP;
    endcase
    if (rrr_fmt) begin
      a_addr = ir[RS-1:0];
      b_addr = ir[2*RS-1:RS];
      c_addr = ir[3*RS-1:2*RS];
    end
  end

  assign bus_a    = regs[a_addr];
  assign bus_b    = regs[b_addr];
  assign bus_c    = c_sel ? alu_out : data_in;
  assign data_out = bus_a;
  assign ram_addr = addr_sel ? mem_addr : pc;

`ifdef KS_DP_MUL_EN
  logic [2*DATA_W-1:0] product;

  ks_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (alu_start && (op == OP_MUL)),
    .a       (bus_a),
    .b       (bus_b),
    .busy    (alu_busy),
    .done    (alu_done),
    .product (product)
  );
`else
  logic unused_alu_start;
  assign unused_alu_start = alu_start;
  assign alu_busy = 1'b0;
  assign alu_done = 1'b0;
`endif

  // SUB reuses the adder as a + ~b + 1; carry into the MSB is recovered from the sum bit.
  always_comb begin
    alu_out = '0;
    alu_uov = 1'b0;
    alu_sov = 1'b0;
    b_op    = (op == OP_SUB) ? ~bus_b : bus_b;
    cin     = (op == OP_SUB);
    sum_ext = {1'b0, bus_a} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};
    carry_into_msb = sum_ext[DATA_W-1] ^ bus_a[DATA_W-1] ^ b_op[DATA_W-1];
    case (op)
      OP_OR:  alu_out = bus_a | bus_b;
      OP_AND: alu_out = bus_a & bus_b;
      OP_ADD, OP_SUB: begin
        alu_out = sum_ext[DATA_W-1:0];
        alu_uov = sum_ext[DATA_W];
        alu_sov = carry_into_msb ^ sum_ext[DATA_W];
      end
      OP_SHL: begin
        alu_out = {bus_a[DATA_W-2:0], 1'b0};
        alu_uov = bus_a[DATA_W-1];
        alu_sov = bus_a[DATA_W-1] ^ bus_a[DATA_W-2];
      end
      OP_SHR: begin
        alu_out = {1'b0, bus_a[DATA_W-1:1]};
        alu_uov = bus_a[0];
      end
`ifdef KS_DP_MUL_EN
      OP_MUL: begin
        alu_out = product[DATA_W-1:0];
        alu_uov = |product[2*DATA_W-1:DATA_W];
        alu_sov = (|product[2*DATA_W-1:DATA_W]) | product[DATA_W-1];
      end
`endif
      default: alu_out = bus_a;
    endcase
  end

  // PC, IR and registers all sample pre-edge values, so simultaneous enables are safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (pc_enable) pc <= branch ? mem_addr : pc + ADDR_W'(1);
      if (ir_enable) ir <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_reg_enable) begin
      regs[c_addr] <= bus_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_op           <= ~|alu_out;
      neg_op            <= alu_out[DATA_W-1];
      unsigned_overflow <= alu_uov;
      signed_overflow   <= alu_sov;
    end
  end

endmodule

// File: tb/tb_ks_data_path_gen.sv
// Bench for ks_data_path_gen: default 16-bit/4-register instance plus a 32-bit/8-register one.
// MUL scenarios run when KS_DP_MUL_EN is defined, the disabled-feature scenario otherwise.
module tb_ks_data_path_gen;
  import k_and_s_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int WDW = 32;

  logic clk;
  logic rst;

  logic branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable, alu_start;
  logic [2:0] operation;
  logic alu_busy, alu_done, zero_op, neg_op, uov, sov;
  decoded_instruction_type dec;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] data_out, data_in;

  logic w_branch, w_pc_enable, w_ir_enable, w_addr_sel, w_c_sel, w_write_reg_enable, w_flags_reg_enable, w_alu_start;
  logic [2:0] w_operation;
  logic w_alu_busy, w_alu_done, w_zero_op, w_neg_op, w_uov, w_sov;
  decoded_instruction_type w_dec;
  logic [AW-1:0] w_ram_addr;
  logic [WDW-1:0] w_data_out, w_data_in;

  int tests = 0;
  int fails = 0;

  logic [DW+3:0]  exp_q[$];
  logic [WDW+3:0] w_exp_q[$];

  logic [7:0] dec_opc [18] = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h01, 8'h02,
                               8'h03, 8'h05, 8'h06, 8'h0A, 8'hFF, 8'hA6, 8'hA7, 8'h00, 8'h04};
  decoded_instruction_type dec_exp [18] = '{I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
                               I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_HALT,
                               I_SHL, I_SHR, I_NOP, I_NOP};

  ks_data_path_gen #(.DATA_W(DW), .NUM_REGS(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .operation(operation), .alu_start(alu_start),
    .alu_busy(alu_busy), .alu_done(alu_done), .decoded_instruction(dec),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov), .signed_overflow(sov),
    .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in)
  );

  ks_data_path_gen #(.DATA_W(WDW), .NUM_REGS(8), .ADDR_W(AW)) dut_w (
    .clk(clk), .rst(rst), .branch(w_branch), .pc_enable(w_pc_enable), .ir_enable(w_ir_enable),
    .addr_sel(w_addr_sel), .c_sel(w_c_sel), .write_reg_enable(w_write_reg_enable),
    .flags_reg_enable(w_flags_reg_enable), .operation(w_operation), .alu_start(w_alu_start),
    .alu_busy(w_alu_busy), .alu_done(w_alu_done), .decoded_instruction(w_dec),
    .zero_op(w_zero_op), .neg_op(w_neg_op), .unsigned_overflow(w_uov), .signed_overflow(w_sov),
    .ram_addr(w_ram_addr), .data_out(w_data_out), .data_in(w_data_in)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    write_reg_enable = 0; flags_reg_enable = 0; alu_start = 0; operation = 3'd7; data_in = '0;
    w_branch = 0; w_pc_enable = 0; w_ir_enable = 0; w_addr_sel = 0; w_c_sel = 0;
    w_write_reg_enable = 0; w_flags_reg_enable = 0; w_alu_start = 0; w_operation = 3'd7; w_data_in = '0;
  endtask

  task automatic load_ir(input logic [DW-1:0] v);
    data_in = v; ir_enable = 1; tick(); ir_enable = 0;
  endtask

  task automatic write_reg(input logic [1:0] idx, input logic [DW-1:0] v);
    load_ir({8'h81, 1'b0, idx, 5'd0});
    data_in = v; c_sel = 0; write_reg_enable = 1; tick(); write_reg_enable = 0;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [DW-1:0] v);
    load_ir({8'h82, 1'b0, idx, 5'd0});
    v = data_out;
  endtask

  task automatic run_op(input logic [7:0] opc, input logic [2:0] op, input logic [1:0] c, b, a);
    load_ir({opc, 2'b00, c, b, a});
    operation = op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1; tick();
    c_sel = 0; write_reg_enable = 0; flags_reg_enable = 0;
  endtask

  task automatic w_load_ir(input logic [WDW-1:0] v);
    w_data_in = v; w_ir_enable = 1; tick(); w_ir_enable = 0;
  endtask

  task automatic w_write_reg(input logic [2:0] idx, input logic [WDW-1:0] v);
    w_load_ir({8'h81, 16'd0, idx, 5'd0});
    w_data_in = v; w_c_sel = 0; w_write_reg_enable = 1; tick(); w_write_reg_enable = 0;
  endtask

  task automatic w_read_reg(input logic [2:0] idx, output logic [WDW-1:0] v);
    w_load_ir({8'h82, 16'd0, idx, 5'd0});
    v = w_data_out;
  endtask

  task automatic w_run_op(input logic [7:0] opc, input logic [2:0] op, input logic [2:0] c, b, a);
    w_load_ir({opc, 15'd0, c, b, a});
    w_operation = op; w_c_sel = 1; w_write_reg_enable = 1; w_flags_reg_enable = 1; tick();
    w_c_sel = 0; w_write_reg_enable = 0; w_flags_reg_enable = 0;
  endtask

  // Reference ALU: returns {zero, neg, uov, sov, result}
  function automatic logic [DW+3:0] model(input logic [2:0] op, input logic [DW-1:0] a, b);
    logic [DW-1:0] r;
    logic u, s;
    u = 0; s = 0; r = a;
    case (op)
      3'd0: r = a | b;
      3'd1: begin
        r = a + b;
        u = ((32'(a) + 32'(b)) > 32'hFFFF);
        s = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      3'd2: begin
        r = a - b;
        u = (a >= b);
        s = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      3'd3: r = a & b;
      3'd4: begin r = a << 1; u = a[DW-1]; s = a[DW-1] ^ a[DW-2]; end
      3'd5: begin r = a >> 1; u = a[0]; end
      default: r = a;
    endcase
    return {(r == '0), r[DW-1], u, s, r};
  endfunction

  task automatic test_reset();
    rst = 1; idle_all();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (ram_addr !== '0) begin fails++; $display("FAIL reset_pc: got %h exp 0", ram_addr); end
    tests++; if (dec !== I_NOP) begin fails++; $display("FAIL reset_dec: got %0d exp %0d", dec, I_NOP); end
    tests++; if ({zero_op, neg_op, uov, sov, alu_busy, alu_done} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b exp 000000", {zero_op, neg_op, uov, sov, alu_busy, alu_done}); end
    tests++; if (w_dec !== I_NOP || w_ram_addr !== '0) begin
      fails++; $display("FAIL reset_wide: got dec %0d pc %h exp 0 0", w_dec, w_ram_addr); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_decode();
    decoded_instruction_type a5_exp;
`ifdef KS_DP_MUL_EN
    a5_exp = I_MUL;
`else
    a5_exp = I_NOP;
`endif
    for (int i = 0; i < 18; i++) begin
      load_ir({dec_opc[i], 8'h00});
      tests++; if (dec !== dec_exp[i]) begin
        fails++; $display("FAIL decode_%h: got %0d exp %0d", dec_opc[i], dec, dec_exp[i]); end
    end
    load_ir(16'hA500);
    tests++; if (dec !== a5_exp) begin fails++; $display("FAIL decode_a5: got %0d exp %0d", dec, a5_exp); end
  endtask

  task automatic test_add_sub();
    logic [DW-1:0] r;
    logic [DW+3:0] e;
    write_reg(2'd1, 16'h7FFF); write_reg(2'd2, 16'h0001);
    exp_q.push_back({4'b0101, 16'h8000});
    run_op(8'hA1, 3'd1, 2'd3, 2'd2, 2'd1);
    e = exp_q.pop_front();
    tests++; if ({zero_op, neg_op, uov, sov} !== e[DW+3:DW]) begin
      fails++; $display("FAIL add_flags: got %b exp %b", {zero_op, neg_op, uov, sov}, e[DW+3:DW]); end
    read_reg(2'd3, r);
    tests++; if (r !== e[DW-1:0]) begin fails++; $display("FAIL add_value: got %h exp %h", r, e[DW-1:0]); end
    write_reg(2'd1, 16'd5); write_reg(2'd2, 16'd5);
    exp_q.push_back({4'b1010, 16'h0000});
    run_op(8'hA2, 3'd2, 2'd3, 2'd2, 2'd1);
    e = exp_q.pop_front();
    tests++; if ({zero_op, neg_op, uov, sov} !== e[DW+3:DW]) begin
      fails++; $display("FAIL sub_flags: got %b exp %b", {zero_op, neg_op, uov, sov}, e[DW+3:DW]); end
    read_reg(2'd3, r);
    tests++; if (r !== e[DW-1:0]) begin fails++; $display("FAIL sub_value: got %h exp %h", r, e[DW-1:0]); end
  endtask

  task automatic test_move();
    logic [DW-1:0] r;
    logic [DW+3:0] e;
    write_reg(2'd1, 16'h5A5A); write_reg(2'd2, 16'h0000);
    exp_q.push_back({4'b0000, 16'h5A5A});
    run_op(8'h91, 3'd7, 2'd0, 2'd2, 2'd1);
    e = exp_q.pop_front();
    read_reg(2'd2, r);
    tests++; if (r !== e[DW-1:0]) begin fails++; $display("FAIL move_value: got %h exp %h", r, e[DW-1:0]); end
  endtask

  task automatic test_random_alu();
    logic [DW-1:0] a, b, r;
    logic [2:0] op;
    logic [3:0] fl;
    logic [DW+3:0] e;
    int idx;
    for (int i = 0; i < 10; i++) begin
      a = DW'($urandom_range(0, 65535));
      b = DW'($urandom_range(0, 65535));
      if (i == 0) a = 16'h8000;
      idx = $urandom_range(0, 6);
      op = (idx == 6) ? 3'd7 : 3'(idx);
      write_reg(2'd1, a); write_reg(2'd2, b);
      exp_q.push_back(model(op, a, b));
      run_op(8'hA1, op, 2'd3, 2'd2, 2'd1);
      fl = {zero_op, neg_op, uov, sov};
      read_reg(2'd3, r);
      e = exp_q.pop_front();
      tests++; if ({fl, r} !== e) begin
        fails++; $display("FAIL rand_alu op%0d a=%h b=%h: got %h exp %h", op, a, b, {fl, r}, e); end
    end
  endtask

  task automatic test_pc();
    load_ir({8'h01, 3'b0, 5'd31});
    branch = 1; pc_enable = 1; tick(); branch = 0;
    tests++; if (ram_addr !== 5'd31) begin fails++; $display("FAIL pc_branch31: got %h exp 1f", ram_addr); end
    tick(); pc_enable = 0;
    tests++; if (ram_addr !== 5'd0) begin fails++; $display("FAIL pc_wrap: got %h exp 00", ram_addr); end
    load_ir(16'h0114);
    branch = 1; pc_enable = 1; tick(); branch = 0;
    tests++; if (ram_addr !== 5'h14) begin fails++; $display("FAIL pc_branch14: got %h exp 14", ram_addr); end
    tick(); pc_enable = 0;
    tests++; if (ram_addr !== 5'h15) begin fails++; $display("FAIL pc_inc: got %h exp 15", ram_addr); end
    addr_sel = 1; #1;
    tests++; if (ram_addr !== 5'h14) begin fails++; $display("FAIL addr_sel_ir: got %h exp 14", ram_addr); end
    addr_sel = 0;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] r;
    load_ir(16'h814A);
    data_in = 16'hBEEF; ir_enable = 1; pc_enable = 1; branch = 1; write_reg_enable = 1; c_sel = 0;
    tick();
    ir_enable = 0; pc_enable = 0; branch = 0; write_reg_enable = 0;
    tests++; if (ram_addr !== 5'h0A) begin fails++; $display("FAIL simul_pc: got %h exp 0a", ram_addr); end
    tests++; if (dec !== I_NOP) begin fails++; $display("FAIL simul_ir: got %0d exp %0d", dec, I_NOP); end
    read_reg(2'd2, r);
    tests++; if (r !== 16'hBEEF) begin fails++; $display("FAIL simul_reg: got %h exp beef", r); end
  endtask

  task automatic test_wide();
    logic [WDW-1:0] r;
    logic [WDW+3:0] e;
    w_write_reg(3'd5, 32'h0001_0000); w_write_reg(3'd3, 32'hFFFF_0001);
    w_exp_q.push_back({4'b0010, 32'h0000_0001});
    w_run_op(8'hA1, 3'd1, 3'd7, 3'd5, 3'd3);
    e = w_exp_q.pop_front();
    tests++; if ({w_zero_op, w_neg_op, w_uov, w_sov} !== e[WDW+3:WDW]) begin
      fails++; $display("FAIL wide_add_flags: got %b exp %b", {w_zero_op, w_neg_op, w_uov, w_sov}, e[WDW+3:WDW]); end
    w_read_reg(3'd7, r);
    tests++; if (r !== e[WDW-1:0]) begin fails++; $display("FAIL wide_add_r7: got %h exp %h", r, e[WDW-1:0]); end
    w_write_reg(3'd3, 32'h8000_0000); w_write_reg(3'd6, 32'h1234_5678);
    w_exp_q.push_back({4'b1011, 32'h0000_0000});
    w_run_op(8'hA6, 3'd4, 3'd6, 3'd0, 3'd3);
    e = w_exp_q.pop_front();
    tests++; if ({w_zero_op, w_neg_op, w_uov, w_sov} !== e[WDW+3:WDW]) begin
      fails++; $display("FAIL wide_shl_flags: got %b exp %b", {w_zero_op, w_neg_op, w_uov, w_sov}, e[WDW+3:WDW]); end
    w_read_reg(3'd6, r);
    tests++; if (r !== e[WDW-1:0]) begin fails++; $display("FAIL wide_shl_r6: got %h exp %h", r, e[WDW-1:0]); end
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] r;
    load_ir({8'h01, 3'b0, 5'd7});
    branch = 1; pc_enable = 1; tick(); branch = 0; pc_enable = 0;
    write_reg(2'd1, 16'h1234); write_reg(2'd0, 16'h8000);
    run_op(8'hA4, 3'd0, 2'd3, 2'd0, 2'd0);
    tests++; if (ram_addr !== 5'd7 || neg_op !== 1'b1) begin
      fails++; $display("FAIL rst_setup: got pc %h neg %b exp 07 1", ram_addr, neg_op); end
    rst = 1; #2;
    tests++; if (ram_addr !== '0 || dec !== I_NOP) begin
      fails++; $display("FAIL rst_async_pc_dec: got pc %h dec %0d exp 00 0", ram_addr, dec); end
    tests++; if ({zero_op, neg_op, uov, sov} !== 4'b0 || data_out !== '0) begin
      fails++; $display("FAIL rst_async_flags: got %b data %h exp 0000 0000", {zero_op, neg_op, uov, sov}, data_out); end
    @(negedge clk); rst = 0;
    read_reg(2'd1, r);
    tests++; if (r !== '0) begin fails++; $display("FAIL rst_r1: got %h exp 0000", r); end
  endtask

`ifdef KS_DP_MUL_EN
  task automatic test_mul();
    logic [DW-1:0] r;
    logic [DW+3:0] e;
    int cyc, done_at, busy_cnt, both, dones;
    write_reg(2'd1, 16'd300); write_reg(2'd2, 16'd300); write_reg(2'd3, 16'h0000);
    exp_q.push_back({4'b0011, 16'h5F90});
    load_ir({8'hA5, 2'b00, 2'd3, 2'd2, 2'd1});
    operation = 3'd6; alu_start = 1; tick(); alu_start = 0;
    cyc = 1; done_at = 0; busy_cnt = 0; both = 0;
    for (int k = 0; k < 40; k++) begin
      if (alu_busy) busy_cnt++;
      if (alu_busy && alu_done) both++;
      if (alu_done) begin
        done_at = cyc;
        c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1; tick();
        c_sel = 0; write_reg_enable = 0; flags_reg_enable = 0;
        break;
      end
      alu_start = (cyc == 5);
      tick(); cyc++;
    end
    alu_start = 0;
    tests++; if (done_at != DW + 1) begin fails++; $display("FAIL mul_done_cycle: got %0d exp %0d", done_at, DW + 1); end
    tests++; if (busy_cnt != DW || both != 0) begin
      fails++; $display("FAIL mul_busy: got busy %0d both %0d exp %0d 0", busy_cnt, both, DW); end
    tests++; if (alu_done !== 1'b0 || alu_busy !== 1'b0) begin
      fails++; $display("FAIL mul_done_pulse: got done %b busy %b exp 0 0", alu_done, alu_busy); end
    e = exp_q.pop_front();
    tests++; if ({zero_op, neg_op, uov, sov} !== e[DW+3:DW]) begin
      fails++; $display("FAIL mul_flags: got %b exp %b", {zero_op, neg_op, uov, sov}, e[DW+3:DW]); end
    read_reg(2'd3, r);
    tests++; if (r !== e[DW-1:0]) begin fails++; $display("FAIL mul_value: got %h exp %h", r, e[DW-1:0]); end
  endtask

  task automatic test_mul_abort();
    int dones;
    write_reg(2'd1, 16'd3); write_reg(2'd2, 16'd4);
    load_ir({8'hA5, 2'b00, 2'd3, 2'd2, 2'd1});
    operation = 3'd6; alu_start = 1; tick(); alu_start = 0;
    repeat (7) tick();
    rst = 1; #1;
    tests++; if (alu_busy !== 1'b0) begin fails++; $display("FAIL mul_abort_busy: got %b exp 0", alu_busy); end
    @(negedge clk); rst = 0;
    dones = 0;
    repeat (25) begin tick(); if (alu_done || alu_busy) dones++; end
    tests++; if (dones != 0) begin fails++; $display("FAIL mul_abort_done: got %0d exp 0", dones); end
  endtask
`else
  task automatic test_no_mul();
    logic [DW-1:0] r;
    logic [DW+3:0] e;
    int act;
    load_ir(16'hA500);
    operation = 3'd6; alu_start = 1; tick(); alu_start = 0;
    act = 0;
    repeat (20) begin if (alu_busy || alu_done) act++; tick(); end
    tests++; if (act != 0) begin fails++; $display("FAIL nomul_busy: got %0d exp 0", act); end
    write_reg(2'd1, 16'h8001); write_reg(2'd2, 16'h0003);
    exp_q.push_back({4'b0100, 16'h8001});
    run_op(8'hA1, 3'd6, 2'd3, 2'd2, 2'd1);
    e = exp_q.pop_front();
    read_reg(2'd3, r);
    tests++; if ({zero_op, neg_op, uov, sov, r} !== e) begin
      fails++; $display("FAIL nomul_pass_a: got %h exp %h", {zero_op, neg_op, uov, sov, r}, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_add_sub();
    test_move();
    test_random_alu();
    test_pc();
    test_simultaneous();
    test_wide();
`ifdef KS_DP_MUL_EN
    test_mul();
    test_mul_abort();
`else
    test_no_mul();
`endif
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
